count_snapshot: RTL
===================

COUNT_SNAPSHOT -- requirements
Module: count_snapshot

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the sampled count value.
REQ-002 SHALL have parameter DEPTH, default 4, number of snapshot entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port count_in  input  WIDTH  free-running count value from the upstream counter.
REQ-006 SHALL have port capture  input  1  request to snapshot count_in on this edge.
REQ-007 SHALL have port out_data  output  WIDTH  oldest stored snapshot.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid snapshot.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port level  output  log2(DEPTH)+1  number of stored snapshots, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag; a capture was dropped.
REQ-012 SHALL have port clear_ovf  input  1  clears overflow.

Function
REQ-013 SHALL act as a first-word-fall-through FIFO of DEPTH snapshots of count_in.
REQ-014 SHALL treat a pop as out_valid=1 and out_ready=1 at a posedge; the head entry is removed.
REQ-015 SHALL treat a push as capture=1 at a posedge with level<DEPTH, or with level=DEPTH and a pop on the same edge.
REQ-016 SHALL store the value of count_in present at the pushing edge, not a later value.
REQ-017 SHALL raise out_valid in the cycle after the push edge when the FIFO was empty (1-cycle latency); out_data then equals the captured value.
REQ-018 SHALL drive out_valid=1 exactly when level>0, and out_data=0 when out_valid=0.
REQ-019 SHALL, on capture with level=DEPTH and no pop, drop the sample, leave contents unchanged and set overflow=1 from the next cycle.
REQ-020 SHALL, on simultaneous push and pop, leave level unchanged and replace the head with the next entry in order.
REQ-021 SHALL ignore a pop when empty; a capture on that edge is still pushed.
REQ-022 SHALL wrap read and write pointers modulo DEPTH, with no loss of ordering.
REQ-023 SHALL clear overflow on clear_ovf=1; if a drop occurs on the same edge, overflow stays 1 (set wins).
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, when reset=0 at a posedge, set level=0, out_valid=0, out_data=0, overflow=0 and both pointers to 0, regardless of capture or out_ready.
REQ-026 SHALL discard all stored snapshots on reset mid-operation; a capture on the reset edge is not stored.
REQ-027 SHALL resume normal operation on the first posedge with reset=1.

Configuration
REQ-028 SHALL, with macro COUNT_SNAPSHOT_DROPCNT_EN defined, add output drop_count (8 bits): +1 per dropped capture, saturating at 255, cleared by clear_ovf (a drop on the same edge yields 1), and reset to 0.
REQ-029 SHALL, without COUNT_SNAPSHOT_DROPCNT_EN, have no drop_count port and no associated logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: reset=0 for 2 edges with capture=1 -> level=0, out_valid=0, out_data=0, overflow=0.
REQ-031 SHALL cover single capture: count_in=8'h11, capture pulse, out_ready=0 -> next cycle out_valid=1, out_data=8'h11, level=1, held until out_ready=1.
REQ-032 SHALL cover fill and overflow: captures of 8'h01..8'h05 with out_ready=0 -> level=4, overflow=1, drain yields 01,02,03,04 (05 lost); drop_count=1 when the macro is enabled.
REQ-033 SHALL cover full simultaneous push/pop: level=4 (01..04), capture 8'hA0 with out_ready=1 -> overflow stays 0, level=4, drain yields 02,03,04,A0.
REQ-034 SHALL cover wrap-around: 10 alternating push/pop pairs of 8'hF8..8'h01 (counter rolling over) -> output order equals capture order, level never exceeds 1.
REQ-035 SHALL cover clear_ovf with a same-edge drop: overflow=1 and level=4, clear_ovf=1 and capture=1 on one edge -> overflow remains 1; clear_ovf alone on a later edge -> overflow=0.

Source files
------------

// File: rtl/count_snapshot.sv
// Snapshot FIFO: captures a free-running count value on request and presents the oldest
// sample first-word-fall-through. Define COUNT_SNAPSHOT_DROPCNT_EN to add the drop_count output.
module count_snapshot #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       count_in,
    input  logic                   capture,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clear_ovf
`ifdef COUNT_SNAPSHOT_DROPCNT_EN
    ,
    output logic [7:0]             drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             full, pop, push, drop;

    assign full = (level_q == FullLevel);
    assign pop  = (level_q != '0) && out_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign push = capture && (!full || pop);
    assign drop = capture && full && !pop;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= count_in;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

`ifdef COUNT_SNAPSHOT_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
